// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants and types for the 40x15 character text display: screen
// geometry, glyph cell size, text RAM address/character types and the write
// scheduler FSM state encoding. Imported by the pixel generator and the text
// write scheduler.
// -----------------------------------------------------------------------------
package text_pkg;

    localparam int TEXT_WIDTH  = 40;
    localparam int TEXT_HEIGHT = 15;
    localparam int TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT;
    localparam int TEXT_SZ     = $clog2(TEXT_LEN);

    localparam int CHAR_WIDTH  = 8;
    localparam int CHAR_HEIGHT = 16;

    typedef logic [TEXT_SZ-1:0] text_addr_t;
    typedef logic [7:0]         text_char_t;

    typedef enum logic {
        IDLE,
        FILL
    } text_wr_state_e;

endpackage

// File: rtl/text_write_scheduler_if.sv
// -----------------------------------------------------------------------------
// text_write_scheduler_if
// Bundles everything the text write scheduler exchanges with the outside:
//   cli_req/cli_addr/cli_data/cli_gnt  per-client write handshake
//   fill_start/addr/len/char           fill command
//   fill_busy/fill_done/err_oob        fill status and error pulse
//   text_wr_ena/data/addr              text RAM write port
// The master modport is the side that issues writes and fills and owns the
// RAM (clients, SoC glue); the slave modport is the scheduler itself.
// -----------------------------------------------------------------------------
interface text_write_scheduler_if
    import text_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = TEXT_SZ
);

    logic [NUM_CLIENTS-1:0]             cli_req;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0] cli_addr;
    logic [NUM_CLIENTS-1:0][7:0]        cli_data;
    logic [NUM_CLIENTS-1:0]             cli_gnt;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] fill_len;
    text_char_t        fill_char;
    logic              fill_busy;
    logic              fill_done;
    logic              err_oob;

    logic              text_wr_ena;
    text_char_t        text_wr_data;
    logic [ADDR_W-1:0] text_wr_addr;

    modport master (
        output cli_req, cli_addr, cli_data,
        input  cli_gnt,
        output fill_start, fill_addr, fill_len, fill_char,
        input  fill_busy, fill_done, err_oob,
        input  text_wr_ena, text_wr_data, text_wr_addr
    );

    modport slave (
        input  cli_req, cli_addr, cli_data,
        output cli_gnt,
        input  fill_start, fill_addr, fill_len, fill_char,
        output fill_busy, fill_done, err_oob,
        output text_wr_ena, text_wr_data, text_wr_addr
    );

endinterface

// File: rtl/text_write_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over N requesters with a combinational one-hot grant.
//   clk, reset  clock and asynchronous active-high reset
//   req         request vector
//   adv         arbitration enable; no grant is issued while it is low
//   gnt         one-hot grant (all zero when nothing is granted)
// The pointer remembers the last granted requester; the search starts at the
// one after it and the pointer only moves when a grant is actually issued.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] gnt_idx;
    logic          found;

    // Walk the requesters starting one past the last winner and take the
    // first active one. Nested loops keep every select constant after
    // unrolling, so no variable-index hardware is produced.
    always_comb begin
        gnt     = '0;
        gnt_idx = last;
        found   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (adv && !found && (j == ((int'(last) + i) % N)) && req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = IW'(j);
                    found   = 1'b1;
                end
            end
        end
    end

    // Reset points at the highest index so that requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= IW'(N - 1);
        end else if (found) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/text_write_scheduler.sv
// -----------------------------------------------------------------------------
// text_write_scheduler
// Owns the single write port of the text RAM. Client writers share it through
// a round-robin req/gnt handshake; a built-in fill engine paints a contiguous
// range of cells with one character and preempts all clients while it runs.
//   clk    clock, also the RAM write clock (clk_text_wr)
//   reset  asynchronous active-high reset
//   bus    slave side of text_write_scheduler_if: client handshake, fill
//          command/status, err_oob and the registered text_wr_* RAM port
// All bus outputs except cli_gnt are registered; cli_gnt is combinational
// so a granted write is accepted in the same cycle.
// -----------------------------------------------------------------------------
module text_write_scheduler #(
    parameter int TEXT_WIDTH  = text_pkg::TEXT_WIDTH,
    parameter int TEXT_HEIGHT = text_pkg::TEXT_HEIGHT,
    parameter int TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
    parameter int TEXT_SZ     = $clog2(TEXT_LEN),
    parameter int NUM_CLIENTS = 2
) (
    input logic                   clk,
    input logic                   reset,
    text_write_scheduler_if.slave bus
);

    localparam logic [TEXT_SZ:0] LEN_X = (TEXT_SZ + 1)'(TEXT_LEN);
    localparam logic [TEXT_SZ:0] ONE_X = (TEXT_SZ + 1)'(1);

    text_pkg::text_wr_state_e state, state_n;

    logic [TEXT_SZ-1:0]   cur_addr, cur_addr_n;
    logic [TEXT_SZ:0]     end_addr, end_addr_n;
    text_pkg::text_char_t fill_chr, fill_chr_n;

    logic                 wr_ena, wr_ena_n;
    logic [TEXT_SZ-1:0]   wr_addr, wr_addr_n;
    text_pkg::text_char_t wr_data, wr_data_n;
    logic                 busy, busy_n;
    logic                 done, done_n;
    logic                 err, err_n;

    logic                   arb_en;
    logic [NUM_CLIENTS-1:0] gnt;
    logic [TEXT_SZ-1:0]     sel_addr;
    text_pkg::text_char_t   sel_data;

    logic [TEXT_SZ:0] fill_sum;
    logic [TEXT_SZ:0] fill_end;
    logic             fill_oob;
    logic             fill_empty;
    logic             last_cell;

    rr_arbiter #(
        .N (NUM_CLIENTS)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.cli_req),
        .adv   (arb_en),
        .gnt   (gnt)
    );

    assign bus.cli_gnt      = gnt;
    assign bus.text_wr_ena  = wr_ena;
    assign bus.text_wr_addr = wr_addr;
    assign bus.text_wr_data = wr_data;
    assign bus.fill_busy    = busy;
    assign bus.fill_done    = done;
    assign bus.err_oob      = err;

    // The end address is one bit wider than a cell address so that start+len
    // can never wrap; it is then clamped to the end of the screen.
    assign fill_sum   = {1'b0, bus.fill_addr} + {1'b0, bus.fill_len};
    assign fill_end   = (fill_sum > LEN_X) ? LEN_X : fill_sum;
    assign fill_oob   = ({1'b0, bus.fill_addr} >= LEN_X);
    assign fill_empty = (bus.fill_len == '0) || fill_oob;
    assign last_cell  = (({1'b0, cur_addr} + ONE_X) == end_addr);

    // Route the single granted client's address and character to the port.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt[i]) begin
                sel_addr = bus.cli_addr[i];
                sel_data = bus.cli_data[i];
            end
        end
    end

    // Next-state and next-output logic. A fill start always wins over client
    // requests in IDLE; empty or off-screen fills finish immediately without
    // entering FILL. In FILL the done pulse is raised together with the last
    // write so both land on the outputs in the same cycle.
    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        end_addr_n = end_addr;
        fill_chr_n = fill_chr;
        wr_ena_n   = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        done_n     = 1'b0;
        err_n      = 1'b0;
        arb_en     = 1'b0;

        unique case (state)
            text_pkg::IDLE: begin
                if (bus.fill_start) begin
                    if (fill_empty) begin
                        done_n = 1'b1;
                        err_n  = fill_oob;
                    end else begin
                        state_n    = text_pkg::FILL;
                        cur_addr_n = bus.fill_addr;
                        end_addr_n = fill_end;
                        fill_chr_n = bus.fill_char;
                    end
                end else begin
                    arb_en = 1'b1;
                    if (|gnt) begin
                        if ({1'b0, sel_addr} < LEN_X) begin
                            wr_ena_n  = 1'b1;
                            wr_addr_n = sel_addr;
                            wr_data_n = sel_data;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            text_pkg::FILL: begin
                wr_ena_n   = 1'b1;
                wr_addr_n  = cur_addr;
                wr_data_n  = fill_chr;
                cur_addr_n = cur_addr + 1'b1;
                if (last_cell) begin
                    state_n = text_pkg::IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = text_pkg::IDLE;
            end
        endcase

        busy_n = (state_n == text_pkg::FILL);
    end

    // State and registered outputs; reset aborts a running fill outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= text_pkg::IDLE;
            cur_addr <= '0;
            end_addr <= '0;
            fill_chr <= '0;
            wr_ena   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            end_addr <= end_addr_n;
            fill_chr <= fill_chr_n;
            wr_ena   <= wr_ena_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

endmodule

// File: tb/tb_text_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_text_write_scheduler
// Self-checking bench for text_write_scheduler with two clients. A table of
// single-cycle client writes, hand-written fill/reset sequences and a random
// phase, all checked cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_text_write_scheduler;

    localparam int NC  = 2;
    localparam int LEN = 600;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    text_write_scheduler_if #(.NUM_CLIENTS(NC), .ADDR_W(10)) bus ();

    text_write_scheduler #(.NUM_CLIENTS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the fill is a queue of cell addresses still to write,
    // clients are served by scanning from the one after the last winner.
    int          mLast;
    int          fillQ[$];
    logic [7:0]  mFillChar;
    logic [NC-1:0] eGnt;
    logic        eEna, eBusy, eDone, eErr;
    logic [9:0]  eAddr;
    logic [7:0]  eData;
    logic [NC-1:0] sGnt;

    typedef struct {
        logic [1:0] req;
        logic [9:0] a0;
        logic [7:0] d0;
        logic [9:0] a1;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic       ena;
        logic [9:0] addr;
        logic [7:0] data;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mLast = NC - 1;
        fillQ.delete();
    endtask

    task automatic modelCycle();
        int fa, fl, fe;
        eGnt  = '0;
        eEna  = 1'b0;
        eDone = 1'b0;
        eErr  = 1'b0;
        eAddr = '0;
        eData = '0;
        if (fillQ.size() > 0) begin
            eEna  = 1'b1;
            eAddr = 10'(fillQ.pop_front());
            eData = mFillChar;
            eDone = (fillQ.size() == 0);
        end else if (bus.fill_start) begin
            fa = int'(bus.fill_addr);
            fl = int'(bus.fill_len);
            fe = (fa + fl > LEN) ? LEN : fa + fl;
            if (fl == 0 || fa >= LEN) begin
                eDone = 1'b1;
                eErr  = (fa >= LEN);
            end else begin
                for (int a = fa; a < fe; a++) fillQ.push_back(a);
                mFillChar = bus.fill_char;
            end
        end else begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (mLast + k) % NC;
                if (bus.cli_req[c]) begin
                    eGnt[c] = 1'b1;
                    mLast   = c;
                    if (int'(bus.cli_addr[c]) < LEN) begin
                        eEna  = 1'b1;
                        eAddr = bus.cli_addr[c];
                        eData = bus.cli_data[c];
                    end else begin
                        eErr = 1'b1;
                    end
                    break;
                end
            end
        end
        eBusy = (fillQ.size() > 0);
    endtask

    task automatic clearInputs();
        bus.cli_req    = '0;
        bus.cli_addr   = '0;
        bus.cli_data   = '0;
        bus.fill_start = 1'b0;
        bus.fill_addr  = '0;
        bus.fill_len   = '0;
        bus.fill_char  = '0;
    endtask

    // One clock cycle: inputs are already set; grant is checked mid-cycle,
    // registered outputs just after the edge.
    task automatic applyStimulus();
        @(negedge clk);
        modelCycle();
        sGnt = bus.cli_gnt;
        checkOutput("cli_gnt", 32'(bus.cli_gnt), 32'(eGnt));
        @(posedge clk);
        #1;
        checkOutput("text_wr_ena", 32'(bus.text_wr_ena), 32'(eEna));
        if (eEna) begin
            checkOutput("text_wr_addr", 32'(bus.text_wr_addr), 32'(eAddr));
            checkOutput("text_wr_data", 32'(bus.text_wr_data), 32'(eData));
        end
        checkOutput("fill_busy", 32'(bus.fill_busy), 32'(eBusy));
        checkOutput("fill_done", 32'(bus.fill_done), 32'(eDone));
        checkOutput("err_oob", 32'(bus.err_oob), 32'(eErr));
    endtask

    task automatic releaseGranted();
        for (int c = 0; c < NC; c++) if (sGnt[c]) bus.cli_req[c] = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ena", 32'(bus.text_wr_ena), 0);
        checkOutput("rst_addr", 32'(bus.text_wr_addr), 0);
        checkOutput("rst_data", 32'(bus.text_wr_data), 0);
        checkOutput("rst_busy", 32'(bus.fill_busy), 0);
        checkOutput("rst_done", 32'(bus.fill_done), 0);
        checkOutput("rst_err", 32'(bus.err_oob), 0);
        checkOutput("rst_gnt", 32'(bus.cli_gnt), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
    endtask

    task automatic startFill(input int a, input int l, input logic [7:0] ch);
        bus.fill_start = 1'b1;
        bus.fill_addr  = 10'(a);
        bus.fill_len   = 10'(l);
        bus.fill_char  = ch;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grantCycle, doneCycle, writes, busyCnt, firstBusy, firstWrite, errCnt, doneCnt, lastAddr, cliWrites;
        int order[4];

        reset = 1'b1;
        clearInputs();
        modelReset();

        // Table of single-cycle client writes applied from reset, in order.
        vecs[0] = '{2'b01, 10'd5,    8'h41, 10'd0,   8'h00, 2'b01, 1'b1, 10'd5,   8'h41, 1'b0};
        vecs[1] = '{2'b11, 10'd10,   8'h42, 10'd20,  8'h43, 2'b10, 1'b1, 10'd20,  8'h43, 1'b0};
        vecs[2] = '{2'b11, 10'd10,   8'h42, 10'd20,  8'h43, 2'b01, 1'b1, 10'd10,  8'h42, 1'b0};
        vecs[3] = '{2'b10, 10'd0,    8'h00, 10'd600, 8'h44, 2'b10, 1'b0, 10'd0,   8'h00, 1'b1};
        vecs[4] = '{2'b00, 10'd0,    8'h00, 10'd0,   8'h00, 2'b00, 1'b0, 10'd0,   8'h00, 1'b0};
        vecs[5] = '{2'b01, 10'd599,  8'h7E, 10'd0,   8'h00, 2'b01, 1'b1, 10'd599, 8'h7E, 1'b0};
        vecs[6] = '{2'b10, 10'd0,    8'h00, 10'd0,   8'hFF, 2'b10, 1'b1, 10'd0,   8'hFF, 1'b0};
        vecs[7] = '{2'b11, 10'd1023, 8'h01, 10'd3,   8'h02, 2'b01, 1'b0, 10'd0,   8'h00, 1'b1};

        doReset();
        for (int v = 0; v < 8; v++) begin
            bus.cli_req     = vecs[v].req;
            bus.cli_addr[0] = vecs[v].a0;
            bus.cli_data[0] = vecs[v].d0;
            bus.cli_addr[1] = vecs[v].a1;
            bus.cli_data[1] = vecs[v].d1;
            @(negedge clk);
            checkOutput($sformatf("vec%0d_gnt", v), 32'(bus.cli_gnt), 32'(vecs[v].gnt));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_ena", v), 32'(bus.text_wr_ena), 32'(vecs[v].ena));
            if (vecs[v].ena) begin
                checkOutput($sformatf("vec%0d_addr", v), 32'(bus.text_wr_addr), 32'(vecs[v].addr));
                checkOutput($sformatf("vec%0d_data", v), 32'(bus.text_wr_data), 32'(vecs[v].data));
            end
            checkOutput($sformatf("vec%0d_err", v), 32'(bus.err_oob), 32'(vecs[v].err));
        end

        // Contention: both clients hold req for 4 cycles straight after reset.
        doReset();
        bus.cli_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus.cli_addr[0] = 10'(100 + k);
            bus.cli_data[0] = 8'h30;
            bus.cli_addr[1] = 10'(200 + k);
            bus.cli_data[1] = 8'h31;
            applyStimulus();
            order[k] = int'(sGnt);
        end
        bus.cli_req = '0;
        checkOutput("contention_order", {8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}, 32'h01020102);

        // Full clear with client 0 requesting throughout.
        doReset();
        bus.cli_req     = 2'b01;
        bus.cli_addr[0] = 10'd33;
        bus.cli_data[0] = 8'h55;
        grantCycle = -1; doneCycle = -1; writes = 0; busyCnt = 0; firstBusy = -1; firstWrite = -1;
        for (int c = 0; c <= 602; c++) begin
            if (c == 0) startFill(0, 600, 8'h20);
            applyStimulus();
            if (c == 0) begin
                bus.fill_start = 1'b0;
                checkOutput("clear_start_gnt", 32'(sGnt), 0);
            end
            if (bus.fill_busy) begin
                busyCnt++;
                if (firstBusy < 0) firstBusy = c + 1;
            end
            if (bus.text_wr_ena && bus.text_wr_data == 8'h20) begin
                writes++;
                if (firstWrite < 0) firstWrite = c + 1;
            end
            if (bus.fill_done) doneCycle = c + 1;
            if (sGnt[0] && grantCycle < 0) grantCycle = c;
            releaseGranted();
        end
        checkOutput("clear_writes", writes, 600);
        checkOutput("clear_first_write", firstWrite, 2);
        checkOutput("clear_busy_cycles", busyCnt, 600);
        checkOutput("clear_first_busy", firstBusy, 1);
        checkOutput("clear_done_cycle", doneCycle, 601);
        checkOutput("clear_grant_cycle", grantCycle, 601);

        // Clamped fill at the end of the screen.
        writes = 0; errCnt = 0; doneCnt = 0; lastAddr = -1;
        for (int c = 0; c < 15; c++) begin
            if (c == 0) startFill(590, 40, 8'h2A);
            applyStimulus();
            bus.fill_start = 1'b0;
            if (bus.text_wr_ena) begin
                writes++;
                lastAddr = int'(bus.text_wr_addr);
            end
            if (bus.err_oob) errCnt++;
            if (bus.fill_done) doneCnt++;
        end
        checkOutput("clamp_writes", writes, 10);
        checkOutput("clamp_last_addr", lastAddr, 599);
        checkOutput("clamp_err", errCnt, 0);
        checkOutput("clamp_done", doneCnt, 1);

        // Fill starting off screen finishes at once with an error.
        startFill(700, 5, 8'h21);
        applyStimulus();
        bus.fill_start = 1'b0;
        checkOutput("oob_fill_done", 32'(bus.fill_done), 1);
        checkOutput("oob_fill_err", 32'(bus.err_oob), 1);
        checkOutput("oob_fill_ena", 32'(bus.text_wr_ena), 0);
        applyStimulus();
        checkOutput("oob_fill_done_off", 32'(bus.fill_done), 0);

        // Fill start beats a request; a second start mid-fill is ignored.
        bus.cli_req     = 2'b01;
        bus.cli_addr[0] = 10'd50;
        bus.cli_data[0] = 8'h11;
        writes = 0; cliWrites = 0; errCnt = 0; grantCycle = -1;
        for (int c = 0; c < 13; c++) begin
            if (c == 0) startFill(100, 5, 8'h58);
            if (c == 2) startFill(300, 50, 8'h59);
            applyStimulus();
            bus.fill_start = 1'b0;
            if (c == 0) checkOutput("simul_gnt", 32'(sGnt), 0);
            if (bus.text_wr_ena && bus.text_wr_data == 8'h58) writes++;
            if (bus.text_wr_ena && bus.text_wr_data == 8'h59) errCnt++;
            if (bus.text_wr_ena && bus.text_wr_addr == 10'd50) cliWrites++;
            if (sGnt[0] && grantCycle < 0) grantCycle = c;
            releaseGranted();
        end
        checkOutput("simul_fill_writes", writes, 5);
        checkOutput("simul_second_fill_writes", errCnt, 0);
        checkOutput("simul_client_writes", cliWrites, 1);
        checkOutput("simul_grant_cycle", grantCycle, 6);

        // Reset in the middle of a full-screen fill.
        for (int c = 0; c < 100; c++) begin
            if (c == 0) startFill(0, 600, 8'h20);
            applyStimulus();
            bus.fill_start = 1'b0;
        end
        checkOutput("midfill_ena_before", 32'(bus.text_wr_ena), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midfill_ena", 32'(bus.text_wr_ena), 0);
        checkOutput("midfill_busy", 32'(bus.fill_busy), 0);
        checkOutput("midfill_done", 32'(bus.fill_done), 0);
        doReset();
        bus.cli_req     = 2'b01;
        bus.cli_addr[0] = 10'd7;
        bus.cli_data[0] = 8'h41;
        applyStimulus();
        bus.cli_req = '0;
        checkOutput("post_reset_ena", 32'(bus.text_wr_ena), 1);
        checkOutput("post_reset_addr", 32'(bus.text_wr_addr), 7);
        checkOutput("post_reset_data", 32'(bus.text_wr_data), 32'h41);
        applyStimulus();

        // Random traffic against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NC; k++) begin
                if (!bus.cli_req[k] && $urandom_range(0, 1) == 0) begin
                    bus.cli_req[k]  = 1'b1;
                    bus.cli_addr[k] = 10'($urandom_range(0, 639));
                    bus.cli_data[k] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                startFill(int'($urandom_range(0, 620)), int'($urandom_range(0, 30)), 8'($urandom));
            end else begin
                bus.fill_start = 1'b0;
            end
            applyStimulus();
            releaseGranted();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_write_scheduler.md
# text_write_scheduler

Owns the single write port of the 40x15 text RAM and shares it between several client writers (SPI command decoder, status overlay, etc.) and a built-in fill engine that clears or paints a contiguous range of character cells. Clients use a req/gnt handshake and are served round-robin. The fill engine preempts all clients while it runs. Outputs drive the text RAM write interface (`text_wr_ena/data/addr`) in the same clock domain as `clk_text_wr`.

## Interface
Parameters:
- `TEXT_WIDTH`, 40: characters per text row.
- `TEXT_HEIGHT`, 15: text rows.
- `TEXT_LEN`, `TEXT_WIDTH*TEXT_HEIGHT` (600): number of cells.
- `TEXT_SZ`, `$clog2(TEXT_LEN)` (10): cell address width.
- `NUM_CLIENTS`, 2: number of client write ports, range 1..8.

Ports:
- `clk`  in  1  clock; also wired to the RAM's `clk_text_wr`.
- `reset`  in  1  asynchronous, active-high reset.
- `cli_req`  in  NUM_CLIENTS  per-client write request; held until granted.
- `cli_addr`  in  NUM_CLIENTS x TEXT_SZ  per-client cell address; stable while req is high.
- `cli_data`  in  NUM_CLIENTS x 8  per-client character code; stable while req is high.
- `cli_gnt`  out  NUM_CLIENTS  one-hot grant, combinational; the write is accepted in that cycle.
- `fill_start`  in  1  single-cycle pulse that starts a fill.
- `fill_addr`  in  TEXT_SZ  first cell to fill; sampled with `fill_start`.
- `fill_len`  in  TEXT_SZ  number of cells to fill; sampled with `fill_start`.
- `fill_char`  in  8  character written to every filled cell; sampled with `fill_start`.
- `fill_busy`  out  1  high while the fill engine owns the port.
- `fill_done`  out  1  one-cycle pulse when the fill completes.
- `err_oob`  out  1  one-cycle pulse when an out-of-range write or fill start is dropped.
- `text_wr_ena`  out  1  RAM write enable, registered.
- `text_wr_data`  out  8  RAM write data, registered.
- `text_wr_addr`  out  TEXT_SZ  RAM write address, registered.

## Operation
- The FSM has two states, IDLE and FILL. All outputs reset to 0 and the state resets to IDLE.
- **IDLE, `fill_start`=1:**
  - Latch `fill_char` and the current address `fill_addr`.
  - Latch the end address as `min(fill_addr + fill_len, TEXT_LEN)`, computed TEXT_SZ+1 wide with no wrap.
  - Go to FILL.
  - No client is granted that cycle; `fill_start` beats any simultaneous request.
- **IDLE, no start:**
  - The round-robin arbiter grants at most one requesting client per cycle.
  - Search starts at the client after the last granted one.
  - The pointer advances only on a grant.
- **Granted client:**
  - If `cli_addr < TEXT_LEN`, the registered outputs next cycle carry ena=1 and that addr/data.
  - Otherwise there is no write (ena=0), but the grant still happens and `err_oob` pulses next cycle.
- **FILL:**
  - Each cycle issues a write of `fill_char` at the current address, then increments the address.
  - When the address that was just issued equals end-1, go to IDLE and pulse `fill_done` next cycle.
  - `cli_gnt` stays 0 throughout FILL.
  - `fill_start` during FILL is ignored and does not set `err_oob`.
- **Zero-length or fully out-of-range fill:**
  - Applies when `fill_len`=0 or `fill_addr >= TEXT_LEN`.
  - No FILL state, no writes, and `fill_done` pulses next cycle.
  - `err_oob` also pulses next cycle if `fill_addr >= TEXT_LEN`.
- **Partially out-of-range fill:** it is clamped at cell TEXT_LEN-1 and no error is flagged.
- **Reset asserted mid-fill:** the fill aborts immediately. All outputs and the RR pointer clear, and no `fill_done` is produced.

## Timing
- **Client write:**
  - With req high in cycle N and `cli_gnt` high in cycle N, the write appears on `text_wr_*` in cycle N+1.
  - A client may present its next write in cycle N+1, giving a sustained 1 write/cycle.
- **Fill:**
  - With `fill_start` in cycle 0, `fill_busy` is high in cycles 1..L, where L is the clamped length.
  - Writes appear in cycles 2..L+1 at consecutive addresses.
  - `fill_done` pulses in cycle L+1, coincident with the last write.
  - Clients can be granted again from cycle L+1.
- **Latency:** one cycle on every path.
- **Registered outputs:** all of `text_wr_*`, `fill_busy`, `fill_done` and `err_oob`. `cli_gnt` is combinational from state and `cli_req`.

## Structure
- **Shared package `text_pkg`:**
  - `TEXT_WIDTH`, `TEXT_HEIGHT`, `TEXT_LEN` and `CHAR_WIDTH`/`CHAR_HEIGHT` constants.
  - `text_addr_t`, a `logic [TEXT_SZ-1:0]`.
  - `text_char_t`, a `logic [7:0]`.
  - The FSM state enum `text_wr_state_e`.
  - The pixel generator and this block both import it.
- **Sub-module `rr_arbiter`:**
  - Parameterized by N.
  - Inputs: req vector, an advance enable, and the asynchronous reset.
  - Output: a one-hot gnt.
  - Holds the RR pointer internally.

## Test plan
- **Single client:** client0 writes 'A' (8'h41) to addr 5 → gnt0 in the same cycle; next cycle ena=1, addr=5, data=8'h41; a single write.
- **Contention:** both clients hold req for 4 cycles → grants alternate 0,1,0,1 after reset; write addresses follow the grant order; no cycle has two grants.
- **Full clear:**
  - Stimulus: `fill_start` with addr=0, len=600, char=8'h20.
  - Response: 600 consecutive writes of addr 0..599 in cycles 2..601; `fill_busy` in cycles 1..600; `fill_done` in cycle 601.
  - A client req held throughout is granted in cycle 601.
- **Clamp and errors:**
  - Fill with addr=590, len=40 → 10 writes (590..599), no `err_oob`.
  - Fill with addr=700 → `fill_done` and `err_oob` in cycle 1, no writes.
  - Client addr=600 → gnt, no write, `err_oob`.
- **Simultaneous events:** `fill_start` and req in the same cycle → no gnt that cycle. A second `fill_start` mid-fill is ignored and the original range completes.
- **Reset mid-fill:** assert reset at cycle 100 of a 600-cell fill → `text_wr_ena`, `fill_busy` and `fill_done` go 0 immediately; after release, a client write completes normally.
